// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU. It takes the 3-bit alucontrol code from the ALU decoder
// and two register operands. It produces a registered result and zero flag
// for the memory/writeback path.
//
// Single-cycle ops (add, sub, and, or, slt, reserved) produce their result on
// the edge that accepts them. Multiply is an iterative shift-add. While it
// runs, in_ready is held low so the upstream pipeline stalls.
//
// Build option:
//   ALU_MUL_RADIX4_EN - when defined, the multiplier retires two multiplier
//                       bits per cycle, so it needs WIDTH/2 iterations. When
//                       undefined, it retires one bit per cycle and needs
//                       WIDTH iterations.
//
// Parameters:
//   WIDTH       operand/result width in bits (even, >= 4)
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   in_valid    upstream presents an operation
//   in_ready    unit accepts an operation this cycle
//   alucontrol  000 add, 001 sub, 010 and, 011 or, 100 mul (low WIDTH bits),
//               101 slt (signed), 110/111 reserved (result 0)
//   src_a       operand A
//   src_b       operand B
//   out_valid   result/zero valid
//   out_ready   downstream consumes the result
//   result      registered result
//   zero        registered (result == 0)
//   busy        high while a multiply is iterating
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alucontrol,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    // -------------------------------------------------------------------------
    // Operation codes
    // -------------------------------------------------------------------------
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    // -------------------------------------------------------------------------
    // Multiplier iteration count
    // -------------------------------------------------------------------------
`ifdef ALU_MUL_RADIX4_EN
    localparam int MUL_STEPS = WIDTH / 2;
`else
    localparam int MUL_STEPS = WIDTH;
`endif

    // The counter must be able to hold WIDTH itself, hence WIDTH+1.
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Single-cycle operation result
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] alu_single(
        input logic [2:0]       code,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] y;
        y = '0;
        case (code)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            // Reserved codes return zero. Multiply never reaches this function.
            default: y = '0;
        endcase
        return y;
    endfunction

    // -------------------------------------------------------------------------
    // Partial product added to the accumulator in one multiply iteration.
    // The low multiplier bits select a multiple of the shifted multiplicand.
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] mul_addend(
        input logic [WIDTH-1:0] mcand,
        input logic [WIDTH-1:0] mplier
    );
        logic [WIDTH-1:0] p;
        p = '0;
`ifdef ALU_MUL_RADIX4_EN
        case (mplier[1:0])
            2'b00:   p = '0;
            2'b01:   p = mcand;
            2'b10:   p = mcand << 1;
            default: p = mcand + (mcand << 1);
        endcase
`else
        p = mplier[0] ? mcand : '0;
`endif
        return p;
    endfunction

    // -------------------------------------------------------------------------
    // State and next-state signals
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_out_valid;
    logic             r_busy;

    state_t           w_state_n;
    logic [CNT_W-1:0] w_count_n;
    logic [WIDTH-1:0] w_mcand_n;
    logic [WIDTH-1:0] w_mplier_n;
    logic [WIDTH-1:0] w_acc_n;
    logic [WIDTH-1:0] w_result_n;
    logic             w_zero_n;
    logic             w_out_valid_n;
    logic             w_busy_n;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_single;
    logic [WIDTH-1:0] w_step_acc;

    // A new op may enter only when idle and the output slot is free or being
    // drained on this same edge.
    assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_single   = alu_single(alucontrol, src_a, src_b);
    assign w_step_acc = r_acc + mul_addend(r_mcand, r_mplier);

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_n     = r_state;
        w_count_n     = r_count;
        w_mcand_n     = r_mcand;
        w_mplier_n    = r_mplier;
        w_acc_n       = r_acc;
        w_result_n    = r_result;
        w_zero_n      = r_zero;
        w_out_valid_n = r_out_valid;
        w_busy_n      = r_busy;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (alucontrol == OP_MUL) begin
                        w_mcand_n     = src_a;
                        w_mplier_n    = src_b;
                        w_acc_n       = '0;
                        w_count_n     = CNT_LOAD;
                        w_busy_n      = 1'b1;
                        // Accept implies any pending result was consumed on
                        // this edge, so the output slot empties.
                        w_out_valid_n = 1'b0;
                        w_state_n     = S_MUL;
                    end else begin
                        w_result_n    = w_single;
                        w_zero_n      = (w_single == '0);
                        w_out_valid_n = 1'b1;
                    end
                end else if (r_out_valid && out_ready) begin
                    w_out_valid_n = 1'b0;
                end
            end

            S_MUL: begin
`ifdef ALU_MUL_RADIX4_EN
                w_mcand_n  = r_mcand << 2;
                w_mplier_n = r_mplier >> 2;
`else
                w_mcand_n  = r_mcand << 1;
                w_mplier_n = r_mplier >> 1;
`endif
                w_acc_n    = w_step_acc;
                w_count_n  = r_count - CNT_ONE;

                // Last iteration: the freshly summed accumulator is the
                // product, so it goes straight to the output register.
                if (r_count == CNT_ONE) begin
                    w_result_n    = w_step_acc;
                    w_zero_n      = (w_step_acc == '0);
                    w_out_valid_n = 1'b1;
                    w_busy_n      = 1'b0;
                    w_state_n     = S_IDLE;
                end
            end

            default: begin
                w_state_n = S_IDLE;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_count     <= w_count_n;
            r_mcand     <= w_mcand_n;
            r_mplier    <= w_mplier_n;
            r_acc       <= w_acc_n;
            r_result    <= w_result_n;
            r_zero      <= w_zero_n;
            r_out_valid <= w_out_valid_n;
            r_busy      <= w_busy_n;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign busy      = r_busy;

endmodule
